// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the framed SPI initiator.
// Holds the FSM state enum, frame overhead and idle line levels.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    // SETUP + START + STOP periods around the payload
    localparam int SPI_FRAME_OVERHEAD = 3;

    localparam logic IDLE_CS_N    = 1'b1;
    localparam logic IDLE_START_N = 1'b1;
    localparam logic IDLE_SCLK    = 1'b0;
    localparam logic IDLE_MOSI    = 1'b1;

endpackage

// File: rtl/spi_frame_master_sclk_gen.sv
// Serial clock generator: divider counter plus half-phase flag.
// Ports: clear (start a frame), halt (end a frame), sclk, period_start, sample.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic halt,
    output logic sclk,
    output logic period_start,
    output logic sample
);
    import spi_frame_pkg::*;

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       half;
    logic       running;
    logic       wrap;

    assign wrap = (cnt == LAST);

    // half=0 is the high half of the period, half=1 the low half
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 8'd0;
            half    <= 1'b0;
            running <= 1'b0;
            sclk    <= IDLE_SCLK;
        end else if (clear) begin
            cnt     <= 8'd0;
            half    <= 1'b0;
            running <= 1'b1;
            sclk    <= 1'b1;
        end else if (halt) begin
            cnt     <= 8'd0;
            half    <= 1'b0;
            running <= 1'b0;
            sclk    <= IDLE_SCLK;
        end else if (running) begin
            if (wrap) begin
                cnt  <= 8'd0;
                half <= ~half;
                sclk <= half;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign period_start = running & ~half & (cnt == 8'd0);
    assign sample       = running & half & wrap;

endmodule

// File: rtl/spi_frame_master.sv
// Framed SPI initiator: sends one byte on MOSI, receives one framed byte on MISO.
// Ports: start/tx_data command in; busy/done/rx_data/frame_err status; cs_n/start_n/sclk/mosi/miso pins.
module spi_frame_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              frame_err,
    output logic              cs_n,
    output logic              start_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);
    import spi_frame_pkg::*;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] TOP_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [CNT_W-1:0]  bit_cnt;
    logic              start_bit;
    logic              accept;
    logic              halt;
    logic              period_start;
    logic              sample;

    assign accept = (state == IDLE) && start;
    assign halt   = (state == STOP) && sample;

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (accept),
        .halt        (halt),
        .sclk        (sclk),
        .period_start(period_start),
        .sample      (sample)
    );

    // Line outputs are loaded on the edge that closes a period, so they
    // change together with the sclk rise that opens the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_sh     <= '0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            start_bit <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= '0;
            frame_err <= 1'b0;
            cs_n      <= IDLE_CS_N;
            start_n   <= IDLE_START_N;
            mosi      <= IDLE_MOSI;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh   <= tx_data;
                        state   <= SETUP;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        start_n <= 1'b1;
                        mosi    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (sample) begin
                        state   <= START;
                        start_n <= 1'b0;
                    end
                end
                START: begin
                    if (sample) begin
                        start_bit <= miso;
                        state     <= DATA;
                        start_n   <= 1'b1;
                        mosi      <= tx_sh[DATA_W-1];
                        bit_cnt   <= TOP_BIT;
                    end
                end
                DATA: begin
                    // MSB already on mosi; expose the next bit early in the period
                    if (period_start) begin
                        tx_sh <= tx_sh << 1;
                    end
                    if (sample) begin
                        rx_sh <= (rx_sh << 1) | DATA_W'(miso);
                        if (bit_cnt == '0) begin
                            state <= STOP;
                            mosi  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - CNT_W'(1);
                            mosi    <= tx_sh[DATA_W-1];
                        end
                    end
                end
                STOP: begin
                    if (sample) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        rx_data   <= rx_sh;
                        frame_err <= start_bit | ~miso;
                        cs_n      <= IDLE_CS_N;
                        start_n   <= IDLE_START_N;
                        mosi      <= IDLE_MOSI;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master at CLK_DIV=4 and CLK_DIV=1.
// A responder model drives framed MISO and captures MOSI on sclk falls.
module tb_spi_frame_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]      start_s, busy_s, done_s, fe_s;
    logic [1:0]      cs_s, sn_s, sclk_s, mosi_s, miso_s;
    logic [1:0][7:0] tx_d, rx_s;

    spi_frame_master #(.DATA_W(8), .CLK_DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .start(start_s[0]), .tx_data(tx_d[0]),
        .busy(busy_s[0]), .done(done_s[0]), .rx_data(rx_s[0]),
        .frame_err(fe_s[0]), .cs_n(cs_s[0]), .start_n(sn_s[0]),
        .sclk(sclk_s[0]), .mosi(mosi_s[0]), .miso(miso_s[0])
    );

    spi_frame_master #(.DATA_W(8), .CLK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .tx_data(tx_d[1]),
        .busy(busy_s[1]), .done(done_s[1]), .rx_data(rx_s[1]),
        .frame_err(fe_s[1]), .cs_n(cs_s[1]), .start_n(sn_s[1]),
        .sclk(sclk_s[1]), .mosi(mosi_s[1]), .miso(miso_s[1])
    );

    localparam logic [14:0] RST_OUTS = {7'b1101000, 8'h00};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder model: period 0 = SETUP, 1 = START, 2..9 = data, 10 = STOP
    int              per[2];
    int              sn_bad[2];
    int              done_cnt[2];
    logic [1:0][7:0] mosi_cap;
    logic [1:0]      prev_sclk = 2'b00;
    logic [1:0]      prev_cs = 2'b11;
    logic [1:0][9:0] fr;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (cs_s[i] !== 1'b0) begin
                per[i] = -1;
                miso_s[i] = 1'b1;
            end else begin
                if (prev_cs[i]) per[i] = 0;
                else if (sclk_s[i] && !prev_sclk[i]) per[i]++;
                miso_s[i] = (per[i] >= 1 && per[i] <= 10) ? fr[i][10-per[i]] : 1'b1;
                if (sn_s[i] !== ((per[i] == 1) ? 1'b0 : 1'b1)) sn_bad[i]++;
                if (!sclk_s[i] && prev_sclk[i] && per[i] >= 2 && per[i] <= 9)
                    mosi_cap[i] = {mosi_cap[i][6:0], mosi_s[i]};
            end
            if (done_s[i] === 1'b1) done_cnt[i]++;
            prev_sclk[i] = sclk_s[i];
            prev_cs[i] = cs_s[i];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [14:0] outs(input int i);
        return {cs_s[i], sn_s[i], sclk_s[i], mosi_s[i], busy_s[i], done_s[i], fe_s[i], rx_s[i]};
    endfunction

    task automatic run_frame(input int i, input logic [7:0] tx, input logic sb,
                             input logic [7:0] d, input logic pb,
                             input logic [7:0] exp_rx, input logic exp_err,
                             input string tag);
        int t0, lat, n, snb0;
        fr[i] = {sb, d, pb};
        lat = 1 + (8 + 3) * 2 * div_of(i);
        snb0 = sn_bad[i];
        tx_d[i] = tx;
        start_s[i] = 1'b1;
        t0 = cyc;
        tick();
        start_s[i] = 1'b0;
        tx_d[i] = ~tx;
        chk({tag, ".launch"}, {29'd0, cs_s[i], busy_s[i], sclk_s[i]}, 32'b011);
        n = 0;
        while (done_s[i] !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, ".done_at"}, cyc - t0, lat);
        chk({tag, ".rx"}, rx_s[i], exp_rx);
        chk({tag, ".ferr"}, fe_s[i], exp_err);
        chk({tag, ".mosi"}, mosi_cap[i], tx);
        chk({tag, ".start_n"}, sn_bad[i] - snb0, 0);
        tick();
        chk({tag, ".end"}, {29'd0, done_s[i], busy_s[i], cs_s[i]}, 32'b001);
    endtask

    typedef struct {
        int         inst;
        logic [7:0] tx;
        logic       sb;
        logic [7:0] d;
        logic       pb;
        logic [7:0] exp_rx;
        logic       exp_err;
    } vec_t;

    vec_t vt[6];

    initial begin
        int bad, n, t0, d1, gap, dc0, i;
        logic [7:0] rtx, rd;
        logic rsb, rpb, rerr;

        vt[0] = '{0, 8'hA9, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b0};
        vt[1] = '{0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[2] = '{0, 8'h5A, 1'b0, 8'h81, 1'b0, 8'h81, 1'b1};
        vt[3] = '{1, 8'hA9, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b0};
        vt[4] = '{1, 8'hC3, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1};
        vt[5] = '{0, 8'hFF, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};

        // Reset with start held: start must be ignored
        rst = 1'b1;
        start_s = 2'b11;
        tx_d[0] = 8'hFF;
        tx_d[1] = 8'hFF;
        fr[0] = '1;
        fr[1] = '1;
        repeat (3) tick();
        chk("reset.outs0", outs(0), RST_OUTS);
        chk("reset.outs1", outs(1), RST_OUTS);
        start_s = 2'b00;
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            for (int k = 0; k < 2; k++)
                if (outs(k) !== RST_OUTS) bad++;
        end
        chk("idle.hold", bad, 0);

        // Directed vectors
        for (int v = 0; v < 6; v++) begin
            run_frame(vt[v].inst, vt[v].tx, vt[v].sb, vt[v].d, vt[v].pb,
                      vt[v].exp_rx, vt[v].exp_err, $sformatf("vec%0d", v));
            tick();
        end

        // Random frames against the framing rules
        repeat (16) begin
            i = int'($urandom_range(0, 1));
            rtx = 8'($urandom);
            rd = 8'($urandom);
            rsb = ($urandom_range(0, 3) == 0);
            rpb = ($urandom_range(0, 3) != 0);
            rerr = (rsb != 1'b0) || (rpb != 1'b1);
            run_frame(i, rtx, rsb, rd, rpb, rd, rerr, "rand");
            repeat ($urandom_range(0, 2)) tick();
        end

        // Back-to-back with start held high
        fr[0] = {1'b0, 8'h96, 1'b1};
        tx_d[0] = 8'h55;
        start_s[0] = 1'b1;
        t0 = cyc;
        tick();
        tx_d[0] = 8'hAA;
        n = 0;
        while (done_s[0] !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        d1 = cyc;
        chk("b2b.first_at", d1 - t0, 89);
        chk("b2b.first_mosi", mosi_cap[0], 8'h55);
        chk("b2b.first_rx", rx_s[0], 8'h96);
        gap = 0;
        n = 0;
        while (cs_s[0] === 1'b1 && n < 10) begin
            gap++;
            tick();
            n++;
        end
        start_s[0] = 1'b0;
        chk("b2b.gap", 32'(gap >= 1 && gap <= 2), 1);
        n = 0;
        while (done_s[0] !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("b2b.spacing", cyc - d1, 90);
        chk("b2b.second_mosi", mosi_cap[0], 8'hAA);
        tick();

        // Reset during DATA bit 4
        fr[0] = {1'b0, 8'hE7, 1'b1};
        tx_d[0] = 8'h3C;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        n = 0;
        while (per[0] < 5 && n < 200) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("rst_mid.in_frame", {31'd0, busy_s[0]}, 1);
        dc0 = done_cnt[0];
        #1 rst = 1'b1;
        #1 chk("rst_mid.outs", outs(0), RST_OUTS);
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("rst_mid.no_done", done_cnt[0] - dc0, 0);
        chk("rst_mid.idle", outs(0), RST_OUTS);
        run_frame(0, 8'h96, 1'b0, 8'h4B, 1'b1, 8'h4B, 1'b0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
